// File: rtl/core_ctrl_pkg.sv
// Shared control types for the 5-stage core: sequencer state encoding and
// the per-stage enable/flush bundle driven by pipeline_ctrl.
package core_ctrl_pkg;

   typedef enum logic [1:0] {
      RUN      = 2'd0,
      MEM_WAIT = 2'd1,
      MD_WAIT  = 2'd2,
      REDIRECT = 2'd3
   } ctrl_state_e;

   typedef struct packed {
      logic pc_en;
      logic if_id_en;
      logic if_id_flush;
      logic id_ex_en;
      logic id_ex_flush;
      logic ex_mem_en;
      logic mem_wb_en;
   } stage_ctrl_t;

   // Redirect squash counter is sized for the largest supported FLUSH_CYCLES (15).
   localparam int REDIR_CNT_W = 4;

   function automatic stage_ctrl_t make_ctrl(input logic pc, input logic if_en,
                                             input logic if_fl, input logic id_en,
                                             input logic id_fl, input logic ex_en,
                                             input logic wb_en);
      stage_ctrl_t c;
      c.pc_en       = pc;
      c.if_id_en    = if_en;
      c.if_id_flush = if_fl;
      c.id_ex_en    = id_en;
      c.id_ex_flush = id_fl;
      c.ex_mem_en   = ex_en;
      c.mem_wb_en   = wb_en;
      return c;
   endfunction

endpackage

// File: rtl/sat_counter.sv
// Event counter that sticks at all-ones instead of wrapping.
module sat_counter #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             inc,
   output logic [CNT_W-1:0] count
);

   always_ff @(posedge clk) begin
      if (rst) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// Stall/flush sequencer: merges hazard requests and multi-cycle resource waits
// into per-stage enable/flush controls, with saturating stall/flush counters.
module pipeline_ctrl
   import core_ctrl_pkg::*;
#(
   parameter int FLUSH_CYCLES = 1,
   parameter int MD_TIMEOUT   = 64,
   parameter int CNT_W        = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             hazard_stall,
   input  logic             hazard_flush,
   input  logic             dmem_req,
   input  logic             dmem_ready,
   input  logic             md_start,
   input  logic             md_done,
   output logic             pc_en,
   output logic             if_id_en,
   output logic             if_id_flush,
   output logic             id_ex_en,
   output logic             id_ex_flush,
   output logic             ex_mem_en,
   output logic             mem_wb_en,
   output logic             md_timeout,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   localparam int MD_CNT_W = $clog2(MD_TIMEOUT + 1);

   ctrl_state_e            state, state_nxt;
   logic                   flush_pending, flush_pending_nxt;
   logic [REDIR_CNT_W-1:0] redir_cnt, redir_cnt_nxt;
   logic [MD_CNT_W-1:0]    md_cnt, md_cnt_nxt, md_cnt_inc;
   logic                   md_timeout_nxt;
   stage_ctrl_t            ctrl;

   logic mem_freeze, md_freeze, eff_run, do_redirect, load_use;

   // A released MEM_WAIT / completed MD_WAIT cycle is evaluated exactly like RUN.
   assign mem_freeze  = dmem_req && !dmem_ready;
   assign eff_run     = (state == RUN) || (state == MEM_WAIT) ||
                        ((state == MD_WAIT) && md_done);
   assign md_freeze   = !mem_freeze &&
                        (((state == MD_WAIT) && !md_done) ||
                         (eff_run && md_start && !md_done));
   assign do_redirect = !mem_freeze && !md_freeze && (hazard_flush || flush_pending);
   assign load_use    = !mem_freeze && !md_freeze && !do_redirect &&
                        eff_run && hazard_stall;
   assign md_cnt_inc  = (md_cnt < MD_CNT_W'(MD_TIMEOUT)) ? md_cnt + MD_CNT_W'(1) : md_cnt;

   // State register and the small bookkeeping registers that travel with it.
   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= RUN;
         flush_pending <= 1'b0;
         redir_cnt     <= '0;
         md_cnt        <= '0;
         md_timeout    <= 1'b0;
      end else begin
         state         <= state_nxt;
         flush_pending <= flush_pending_nxt;
         redir_cnt     <= redir_cnt_nxt;
         md_cnt        <= md_cnt_nxt;
         md_timeout    <= md_timeout_nxt;
      end
   end

   // Next-state logic, following the freeze > mul/div > redirect priority.
   always_comb begin
      state_nxt         = state;
      flush_pending_nxt = flush_pending;
      redir_cnt_nxt     = redir_cnt;
      md_cnt_nxt        = '0;
      md_timeout_nxt    = md_timeout;
      if ((state == MD_WAIT) && (md_cnt_inc >= MD_CNT_W'(MD_TIMEOUT))) begin
         md_timeout_nxt = 1'b1;
      end
      if (mem_freeze) begin
         state_nxt = MEM_WAIT;
         if (hazard_flush) flush_pending_nxt = 1'b1;
      end else if (md_freeze) begin
         state_nxt = MD_WAIT;
         if (hazard_flush) flush_pending_nxt = 1'b1;
         if (state == MD_WAIT) md_cnt_nxt = md_cnt_inc;
      end else if (do_redirect) begin
         flush_pending_nxt = 1'b0;
         if (FLUSH_CYCLES > 1) begin
            state_nxt     = REDIRECT;
            redir_cnt_nxt = REDIR_CNT_W'(FLUSH_CYCLES - 1);
         end else begin
            state_nxt = RUN;
         end
      end else if (state == REDIRECT) begin
         if (redir_cnt <= REDIR_CNT_W'(1)) begin
            state_nxt = RUN;
         end else begin
            redir_cnt_nxt = redir_cnt - REDIR_CNT_W'(1);
         end
      end else begin
         state_nxt = RUN;
      end
   end

   // Same-cycle stage controls; fields are pc, if_id en/flush, id_ex en/flush, ex_mem, mem_wb.
   always_comb begin
      ctrl = make_ctrl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
      if (rst) begin
         ctrl = make_ctrl(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
      end else if (mem_freeze) begin
         ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
      end else if (md_freeze) begin
         ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
      end else if (do_redirect) begin
         ctrl = make_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1);
      end else if (state == REDIRECT) begin
         ctrl = make_ctrl(1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1);
      end else if (load_use) begin
         ctrl = make_ctrl(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1);
      end
   end

   assign pc_en       = ctrl.pc_en;
   assign if_id_en    = ctrl.if_id_en;
   assign if_id_flush = ctrl.if_id_flush;
   assign id_ex_en    = ctrl.id_ex_en;
   assign id_ex_flush = ctrl.id_ex_flush;
   assign ex_mem_en   = ctrl.ex_mem_en;
   assign mem_wb_en   = ctrl.mem_wb_en;

   sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!rst && !ctrl.pc_en),
      .count (stall_cnt)
   );

   sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rst   (rst),
      .inc   (!rst && do_redirect),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Directed bench for pipeline_ctrl with FLUSH_CYCLES=3, MD_TIMEOUT=8, CNT_W=4;
// expected control words are hand-derived constants.
module tb_pipeline_ctrl;

   logic       clk;
   logic       rst;
   logic       hazard_stall, hazard_flush, dmem_req, dmem_ready, md_start, md_done;
   logic       pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en;
   logic       md_timeout;
   logic [3:0] stall_cnt, flush_cnt;
   logic [6:0] ctrl_vec;

   int checkCount = 0;
   int passCount  = 0;

   // Control words ordered {pc, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem, mem_wb}.
   localparam logic [6:0] C_RUN    = 7'b1101011;
   localparam logic [6:0] C_LOAD   = 7'b0001111;
   localparam logic [6:0] C_REDIR0 = 7'b1111111;
   localparam logic [6:0] C_REDIRN = 7'b1111011;
   localparam logic [6:0] C_MEMFRZ = 7'b0000000;
   localparam logic [6:0] C_MDHOLD = 7'b0000001;
   localparam logic [6:0] C_RESET  = 7'b0010100;

   pipeline_ctrl #(
      .FLUSH_CYCLES (3),
      .MD_TIMEOUT   (8),
      .CNT_W        (4)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hazard_stall (hazard_stall),
      .hazard_flush (hazard_flush),
      .dmem_req     (dmem_req),
      .dmem_ready   (dmem_ready),
      .md_start     (md_start),
      .md_done      (md_done),
      .pc_en        (pc_en),
      .if_id_en     (if_id_en),
      .if_id_flush  (if_id_flush),
      .id_ex_en     (id_ex_en),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_en    (ex_mem_en),
      .mem_wb_en    (mem_wb_en),
      .md_timeout   (md_timeout),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   assign ctrl_vec = {pc_en, if_id_en, if_id_flush, id_ex_en, id_ex_flush, ex_mem_en, mem_wb_en};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      checkCount++;
      if (actual === expected) begin
         passCount++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Advance to the next cycle, drive inputs just after the edge, let comb logic settle.
   task automatic applyStimulus(input logic hs, input logic hf, input logic dreq,
                                input logic drdy, input logic mst, input logic mdn);
      @(posedge clk);
      #1;
      hazard_stall = hs;
      hazard_flush = hf;
      dmem_req     = dreq;
      dmem_ready   = drdy;
      md_start     = mst;
      md_done      = mdn;
      #1;
   endtask

   initial begin
      rst = 1'b1;
      hazard_stall = 1'b0; hazard_flush = 1'b0; dmem_req = 1'b0;
      dmem_ready = 1'b0; md_start = 1'b0; md_done = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #2;
      checkOutput("reset_ctrl", 32'(ctrl_vec), 32'(C_RESET));
      rst = 1'b0;
      #1;
      checkOutput("post_reset_ctrl", 32'(ctrl_vec), 32'(C_RUN));
      checkOutput("post_reset_stall_cnt", 32'(stall_cnt), 32'd0);
      checkOutput("post_reset_flush_cnt", 32'(flush_cnt), 32'd0);
      checkOutput("post_reset_md_timeout", 32'(md_timeout), 32'd0);

      // Load-use stall for one cycle.
      applyStimulus(1, 0, 0, 0, 0, 0);
      checkOutput("load_use_ctrl", 32'(ctrl_vec), 32'(C_LOAD));
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("load_use_after_ctrl", 32'(ctrl_vec), 32'(C_RUN));
      checkOutput("load_use_stall_cnt", 32'(stall_cnt), 32'd1);

      // Redirect with three squash cycles.
      applyStimulus(0, 1, 0, 0, 0, 0);
      checkOutput("redir_c0_ctrl", 32'(ctrl_vec), 32'(C_REDIR0));
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("redir_c1_ctrl", 32'(ctrl_vec), 32'(C_REDIRN));
      checkOutput("redir_flush_cnt", 32'(flush_cnt), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("redir_c2_ctrl", 32'(ctrl_vec), 32'(C_REDIRN));
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("redir_c3_ctrl", 32'(ctrl_vec), 32'(C_RUN));

      // Memory wait for four cycles with a redirect arriving mid-freeze.
      for (int k = 1; k <= 4; k++) begin
         applyStimulus(0, (k == 2), 1, 0, 0, 0);
         checkOutput($sformatf("mem_freeze_c%0d_ctrl", k), 32'(ctrl_vec), 32'(C_MEMFRZ));
      end
      applyStimulus(0, 0, 1, 1, 0, 0);
      checkOutput("mem_release_ctrl", 32'(ctrl_vec), 32'(C_REDIR0));
      checkOutput("mem_stall_cnt", 32'(stall_cnt), 32'd5);
      checkOutput("mem_flush_cnt_before", 32'(flush_cnt), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("mem_redir_c1_ctrl", 32'(ctrl_vec), 32'(C_REDIRN));
      checkOutput("mem_flush_cnt_after", 32'(flush_cnt), 32'd2);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("mem_redir_done_ctrl", 32'(ctrl_vec), 32'(C_RUN));

      // Redirect and load-use in the same cycle: redirect wins.
      applyStimulus(1, 1, 0, 0, 0, 0);
      checkOutput("flush_vs_stall_ctrl", 32'(ctrl_vec), 32'(C_REDIR0));
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("flush_vs_stall_stall_cnt", 32'(stall_cnt), 32'd5);
      checkOutput("flush_vs_stall_flush_cnt", 32'(flush_cnt), 32'd3);
      applyStimulus(0, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("flush_vs_stall_done_ctrl", 32'(ctrl_vec), 32'(C_RUN));

      // Mul/div op that overruns the timeout.
      applyStimulus(0, 0, 0, 0, 1, 0);
      checkOutput("md_start_ctrl", 32'(ctrl_vec), 32'(C_MDHOLD));
      for (int i = 1; i <= 9; i++) begin
         applyStimulus(0, 0, 0, 0, 0, 0);
         checkOutput($sformatf("md_wait_c%0d_ctrl", i), 32'(ctrl_vec), 32'(C_MDHOLD));
         if (i >= 8) begin
            checkOutput($sformatf("md_wait_c%0d_timeout", i), 32'(md_timeout), 32'(i == 9));
         end
      end
      applyStimulus(0, 0, 0, 0, 0, 1);
      checkOutput("md_done_ex_mem_en", 32'(ex_mem_en), 32'd1);
      checkOutput("md_done_mem_wb_en", 32'(mem_wb_en), 32'd1);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("md_after_ctrl", 32'(ctrl_vec), 32'(C_RUN));
      checkOutput("md_after_timeout", 32'(md_timeout), 32'd1);
      checkOutput("md_after_stall_cnt", 32'(stall_cnt), 32'd15);

      // Saturation: twenty further stall cycles keep the counter pinned.
      for (int s = 0; s < 20; s++) begin
         applyStimulus(1, 0, 0, 0, 0, 0);
      end
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("sat_stall_cnt", 32'(stall_cnt), 32'd15);
      checkOutput("sat_flush_cnt", 32'(flush_cnt), 32'd3);

      // Reset in the middle of a memory wait with a pending redirect.
      applyStimulus(0, 1, 1, 0, 0, 0);
      applyStimulus(0, 0, 1, 0, 0, 0);
      checkOutput("mid_wait_ctrl", 32'(ctrl_vec), 32'(C_MEMFRZ));
      @(posedge clk);
      #1;
      rst = 1'b1;
      #1;
      checkOutput("mid_wait_reset_ctrl", 32'(ctrl_vec), 32'(C_RESET));
      @(posedge clk);
      #1;
      rst = 1'b0;
      dmem_req = 1'b0;
      #1;
      checkOutput("after_reset_ctrl", 32'(ctrl_vec), 32'(C_RUN));
      checkOutput("after_reset_stall_cnt", 32'(stall_cnt), 32'd0);
      checkOutput("after_reset_flush_cnt", 32'(flush_cnt), 32'd0);
      checkOutput("after_reset_md_timeout", 32'(md_timeout), 32'd0);
      applyStimulus(0, 0, 0, 0, 0, 0);
      checkOutput("after_reset_no_pending_ctrl", 32'(ctrl_vec), 32'(C_RUN));
      checkOutput("after_reset_no_pending_flush", 32'(flush_cnt), 32'd0);

      $display("%0d/%0d checks passed", passCount, checkCount);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage core. Combines per-cycle hazard indications (load-use stall, branch mispredict) with multi-cycle resource waits (data memory, mul/div unit) into per-stage enable and flush controls. Holds a small FSM for memory/mul-div freezes and multi-cycle redirect squashing. Keeps saturating performance counters for stall and flush events.

Parameters:
FLUSH_CYCLES, 1, cycles IF/ID is squashed after a redirect (covers imem latency); range 1..15
MD_TIMEOUT, 64, max MD_WAIT cycles before md_timeout is raised
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  core clock
rst  in  1  reset; one clock; reset is synchronous and active-high
hazard_stall  in  1  load-use stall request from hazard detection
hazard_flush  in  1  branch mispredict / redirect request
dmem_req  in  1  MEM stage has an outstanding data access
dmem_ready  in  1  data memory completes the access this cycle
md_start  in  1  EX stage issues a mul/div op this cycle
md_done  in  1  mul/div result valid this cycle
pc_en  out  1  PC register update enable
if_id_en  out  1  IF/ID register enable
if_id_flush  out  1  IF/ID load bubble
id_ex_en  out  1  ID/EX register enable
id_ex_flush  out  1  ID/EX load bubble
ex_mem_en  out  1  EX/MEM register enable
mem_wb_en  out  1  MEM/WB register enable
md_timeout  out  1  sticky: MD_WAIT exceeded MD_TIMEOUT
stall_cnt  out  CNT_W  cycles with pc_en=0 (saturating)
flush_cnt  out  CNT_W  accepted redirects (saturating)

Behaviour:
- States: RUN, MEM_WAIT, MD_WAIT, REDIRECT. Reset -> RUN; counters 0; md_timeout 0; flush_pending 0; redirect counter 0.
- While rst=1: pc_en and all *_en =0, if_id_flush=id_ex_flush=1.
- Control outputs are combinational from state + inputs (same-cycle action). Counters and state are registered.
- Priority per cycle: memory freeze > mul/div freeze > redirect > load-use stall > normal.
- Memory freeze: dmem_req && !dmem_ready (any state) -> all en=0, flushes=0; state MEM_WAIT. Cycle with dmem_ready=1 -> enables as RUN; next state RUN (or REDIRECT if flush_pending).
- Mul/div: md_start && !md_done in RUN -> MD_WAIT. In MD_WAIT: pc_en=if_id_en=id_ex_en=0, ex_mem_en=0, mem_wb_en=1 (drain), flushes=0. md_done -> ex_mem_en=1, next RUN. Wait counter increments each MD_WAIT cycle; reaching MD_TIMEOUT sets md_timeout (sticky until rst); FSM keeps waiting.
- hazard_flush while frozen (MEM_WAIT or MD_WAIT): latched into flush_pending; applied on the release cycle.
- Redirect (RUN, or release with flush_pending): pc_en=1, if_id_flush=1, id_ex_flush=1, all en=1; flush_cnt+1; clear flush_pending. If FLUSH_CYCLES>1 -> REDIRECT with counter=FLUSH_CYCLES-1.
- REDIRECT: pc_en=1, if_id_flush=1, id_ex_flush=0; counter decrements; at 1 -> RUN. New hazard_flush in REDIRECT restarts the counter and increments flush_cnt again.
- Load-use (RUN, no higher event): pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=mem_wb_en=1. Redirect overrides a coincident load-use stall, since the stalled instruction is squashed.
- stall_cnt increments on every non-reset cycle with pc_en=0. Both counters saturate at all-ones and never wrap.
- Reset mid-wait: FSM returns to RUN; flush_pending, md_timeout and counters clear.

Decomposition:
- Shared package core_ctrl_pkg: state encoding (2-bit enum RUN/MEM_WAIT/MD_WAIT/REDIRECT) and the stage-control bundle typedef (pc_en + per-stage en/flush), reused by the core top.
- Sub-module sat_counter (CNT_W, inc, rst) instantiated twice, for stall_cnt and flush_cnt.

Test Plan:
- Load-use: hazard_stall=1 for 1 cycle in RUN -> pc_en=0, if_id_en=0, id_ex_flush=1, ex_mem_en=1; stall_cnt 0->1; next cycle all en=1.
- Redirect, FLUSH_CYCLES=3: hazard_flush 1 cycle -> cycle0 if_id_flush=id_ex_flush=1; cycles1-2 if_id_flush=1 only, state REDIRECT; cycle3 RUN; flush_cnt=1.
- Memory wait plus flush: dmem_req=1, dmem_ready=0 for 4 cycles with hazard_flush pulsed in cycle 2 -> all en=0 for 4 cycles, stall_cnt=4; release cycle applies redirect, flush_cnt=1.
- Mul/div timeout, MD_TIMEOUT=8: md_start with no md_done -> md_timeout=1 after 8 MD_WAIT cycles, mem_wb_en=1 throughout; md_done then returns to RUN with md_timeout still 1.
- Saturation, CNT_W=4: 20 stall cycles -> stall_cnt=15 and stays 15; rst=1 for 1 cycle -> 0.
- Flush plus load-use same cycle -> redirect wins: pc_en=1, id_ex_flush=1, stall_cnt unchanged.
